intrapred_sched: RTL and testbench
==================================

// Module: intrapred_sched
// PURPOSE
//  Frame-level sequencer for the luma intra-prediction datapath.
//  - Walks mbnumber over every macroblock in raster order.
//  - Per MB, runs 16 luma 4x4 steps, then one 16x16 step, driving the datapath enable.
//  - Samples per-step best SAD/mode and picks the MB type: 4x4 sum vs 16x16 SAD.
//  - Presents one result per MB on a valid/ready port to the downstream transform/entropy stage.
// PARAMETERS
//  MB_W        120  frame width in macroblocks
//  MB_H        68   frame height in macroblocks (MB_W*MB_H <= 8192)
//  STEP_CYC    4    cycles per 4x4 step (datapath latency incl. SAD/decision), >=2
//  STEP16_CYC  8    cycles for the 16x16 step, >=2
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  start        in   1   1-cycle pulse: begin frame at MB 0 (ignored unless IDLE)
//  busy         out  1   high from start accept until done
//  done         out  1   1-cycle pulse after last MB result accepted
//  enable       out  1   datapath enable
//  mbnumber     out  13  current macroblock index
//  blk4x4       out  4   current 4x4 sub-block index 0..15 (0 during 16x16 step)
//  sad4_in      in   8   best 4x4 SAD of current step, valid in last step cycle
//  mode4_in     in   3   best 4x4 mode of current step, same timing
//  sad16_in     in   16  best 16x16 SAD, valid in last cycle of 16x16 step
//  mode16_in    in   3   best 16x16 mode, same timing
//  out_valid    out  1   result valid
//  out_ready    in   1   downstream accepts when out_valid & out_ready
//  out_mbnumber out  13  MB index of result
//  out_is16     out  1   1 = 16x16 chosen, 0 = 4x4 chosen
//  out_mode16   out  3   16x16 mode
//  out_modes4   out  48  4x4 modes, blk k in bits [3k+2:3k]
//  out_cost     out  16  SAD of the chosen type
// BEHAVIOUR
//  Reset (async, reset==0): every output 0, FSM=IDLE, all counters and accumulators 0.
//  FSM states: IDLE, RUN4, RUN16, EMIT.
//  - IDLE: start -> RUN4, mbnumber=0, blk4x4=0, step cnt=0, sum4=0; busy=1 from the next cycle.
//  - RUN4: enable=1, cnt counts 0..STEP_CYC-1.
//    - At cnt==STEP_CYC-1: sum4+=sad4_in (12-bit, no overflow), modes4[blk4x4]=mode4_in.
//    - At that edge blk4x4 increments; after blk 15 -> RUN16, cnt=0, blk4x4=0.
//  - RUN16: enable=1 for STEP16_CYC cycles; sad16_in/mode16_in latched in the last cycle -> EMIT.
//  - EMIT: enable=0.
//    - Output regs load on entry; out_valid=1 on the first EMIT cycle.
//    - out_is16 = (sad16 <= {4'b0,sum4}); a tie picks 16x16.
//    - out_cost = chosen SAD, zero-extended to 16 bits.
//    - Outputs hold stable while out_valid & !out_ready (no drop, no change).
//    - On accept: out_valid=0 next cycle.
//      - If mbnumber==MB_W*MB_H-1: done=1 for 1 cycle, busy=0, -> IDLE.
//      - Else: mbnumber+1, sum4=0, -> RUN4.
//  Latency: first RUN4 cycle -> out_valid = 16*STEP_CYC+STEP16_CYC cycles (72 at defaults).
//  start while busy: ignored. out_ready while !out_valid: ignored.
//  mbnumber does not wrap: it stops at the last MB, then returns to 0 only on the next start.
//  Async reset mid-frame: immediate IDLE.
//    - Partial MB is discarded and no done pulse is issued.
//    - A following start restarts at MB 0.
//  enable is registered: enable, mbnumber and blk4x4 change on the same edge.
// TESTING (MB_W=2, MB_H=1, STEP_CYC=4, STEP16_CYC=8)
//  1. Reset, then hold start=0 -> all outputs 0, enable never asserts.
//  2. start; sad4_in=5 every step, sad16_in=100; out_ready=1
//     -> out_valid 72 cycles after start accept; out_is16=0, out_cost=80, mbnumber 0 then 1;
//     -> done pulses once; busy falls with done.
//  3. sad4_in=10 every step, sad16_in=160
//     -> tie: out_is16=1, out_cost=160.
//  4. mode4_in=k%8 for blk k; out_ready low 5 cycles during EMIT
//     -> out_modes4=48'hFAC688_FAC688 held stable for all 5 cycles; enable=0; mbnumber stays 0.
//  5. start pulsed during RUN4 of MB 1 -> ignored; mbnumber sequence unchanged.
//  6. reset asserted at blk4x4=7 of MB 0 -> outputs 0 at once; a new start gives a full first MB
//     with sum4 starting at 0.

Source files
------------

// File: rtl/intrapred_sched.sv
// Frame-level sequencer for luma intra prediction: steps 16 4x4 blocks and one
// 16x16 block per macroblock, picks the cheaper type and hands it downstream.
module intrapred_sched #(
    parameter int MB_W       = 120,
    parameter int MB_H       = 68,
    parameter int STEP_CYC   = 4,
    parameter int STEP16_CYC = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        enable,
    output logic [12:0] mbnumber,
    output logic [3:0]  blk4x4,
    input  logic [7:0]  sad4_in,
    input  logic [2:0]  mode4_in,
    input  logic [15:0] sad16_in,
    input  logic [2:0]  mode16_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] out_mbnumber,
    output logic        out_is16,
    output logic [2:0]  out_mode16,
    output logic [47:0] out_modes4,
    output logic [15:0] out_cost
);
    localparam logic [12:0] LAST_MB    = 13'(MB_W * MB_H - 1);
    localparam logic [15:0] CNT4_LAST  = 16'(STEP_CYC - 1);
    localparam logic [15:0] CNT16_LAST = 16'(STEP16_CYC - 1);

    typedef enum logic [1:0] {IDLE, RUN4, RUN16, EMIT} state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [11:0] r_sum4;
    logic [47:0] r_modes4;
    logic        r_busy, r_done, r_enable, r_out_valid, r_out_is16;
    logic [12:0] r_mbnumber, r_out_mbnumber;
    logic [3:0]  r_blk4x4;
    logic [2:0]  r_out_mode16;
    logic [47:0] r_out_modes4;
    logic [15:0] r_out_cost;

    logic [5:0]  w_mbase;
    logic [15:0] w_sum4_ext;
    logic        w_pick16;

    assign w_mbase    = {2'b00, r_blk4x4} * 6'd3;
    assign w_sum4_ext = {4'b0000, r_sum4};
    // A tie between the two costs favours 16x16.
    assign w_pick16   = (sad16_in <= w_sum4_ext);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_sum4         <= '0;
            r_modes4       <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_enable       <= 1'b0;
            r_mbnumber     <= '0;
            r_blk4x4       <= '0;
            r_out_valid    <= 1'b0;
            r_out_mbnumber <= '0;
            r_out_is16     <= 1'b0;
            r_out_mode16   <= '0;
            r_out_modes4   <= '0;
            r_out_cost     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= RUN4;
                        r_busy     <= 1'b1;
                        r_enable   <= 1'b1;
                        r_mbnumber <= '0;
                        r_blk4x4   <= '0;
                        r_cnt      <= '0;
                        r_sum4     <= '0;
                    end
                end
                RUN4: begin
                    if (r_cnt == CNT4_LAST) begin
                        r_cnt                <= '0;
                        r_sum4               <= r_sum4 + {4'b0000, sad4_in};
                        r_modes4[w_mbase+:3] <= mode4_in;
                        if (r_blk4x4 == 4'd15) begin
                            r_blk4x4 <= '0;
                            r_state  <= RUN16;
                        end else begin
                            r_blk4x4 <= r_blk4x4 + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RUN16: begin
                    if (r_cnt == CNT16_LAST) begin
                        // Result registers load straight from the final 16x16 sample.
                        r_cnt          <= '0;
                        r_enable       <= 1'b0;
                        r_state        <= EMIT;
                        r_out_valid    <= 1'b1;
                        r_out_mbnumber <= r_mbnumber;
                        r_out_is16     <= w_pick16;
                        r_out_mode16   <= mode16_in;
                        r_out_modes4   <= r_modes4;
                        r_out_cost     <= w_pick16 ? sad16_in : w_sum4_ext;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_mbnumber == LAST_MB) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_mbnumber <= r_mbnumber + 13'd1;
                            r_sum4     <= '0;
                            r_enable   <= 1'b1;
                            r_state    <= RUN4;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign enable       = r_enable;
    assign mbnumber     = r_mbnumber;
    assign blk4x4       = r_blk4x4;
    assign out_valid    = r_out_valid;
    assign out_mbnumber = r_out_mbnumber;
    assign out_is16     = r_out_is16;
    assign out_mode16   = r_out_mode16;
    assign out_modes4   = r_out_modes4;
    assign out_cost     = r_out_cost;
endmodule

// File: tb/tb_intrapred_sched.sv
// Bench for intrapred_sched on a 2x1-macroblock frame: directed scenarios plus
// randomized frames checked against a per-MB cost/mode reference model.
module tb_intrapred_sched;
    localparam int MB_W       = 2;
    localparam int MB_H       = 1;
    localparam int STEP_CYC   = 4;
    localparam int STEP16_CYC = 8;
    localparam int NUM_MB     = MB_W * MB_H;
    localparam int LAT        = 16 * STEP_CYC + STEP16_CYC;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic        busy, done, enable, out_valid, out_is16;
    logic [12:0] mbnumber, out_mbnumber;
    logic [3:0]  blk4x4;
    logic [7:0]  sad4_in = '0;
    logic [2:0]  mode4_in = '0, mode16_in = '0, out_mode16;
    logic [15:0] sad16_in = '0, out_cost;
    logic [47:0] out_modes4;

    intrapred_sched #(.MB_W(MB_W), .MB_H(MB_H), .STEP_CYC(STEP_CYC), .STEP16_CYC(STEP16_CYC)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .enable(enable),
        .mbnumber(mbnumber), .blk4x4(blk4x4), .sad4_in(sad4_in), .mode4_in(mode4_in),
        .sad16_in(sad16_in), .mode16_in(mode16_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_mbnumber(out_mbnumber), .out_is16(out_is16), .out_mode16(out_mode16),
        .out_modes4(out_modes4), .out_cost(out_cost)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Stimulus tables, indexed by macroblock and 4x4 block
    int sad4_tab[NUM_MB][16];
    int mode4_tab[NUM_MB][16];
    int sad16_tab[NUM_MB];
    int mode16_tab[NUM_MB];

    // Observations collected by run_frame
    int          n_res, first_valid_j, done_j, done_cnt, done_after, busy_after_start;
    int          busy_bad, emit_enable_bad, emit_mb_bad, unstable, stall_seen, timed_out;
    int          r_mb[8], r_is16[8], r_cost[8], r_mode16[8];
    logic [47:0] r_modes[8];

    function automatic logic [101:0] all_outs();
        return {busy, done, enable, mbnumber, blk4x4, out_valid, out_mbnumber,
                out_is16, out_mode16, out_modes4, out_cost};
    endfunction

    // Reference: 4x4 total is the plain sum of block SADs; 16x16 wins ties.
    function automatic void model(input int mb, output int is16, output int cost,
                                  output logic [47:0] modes);
        int sum = 0;
        modes = '0;
        for (int k = 0; k < 16; k++) begin
            sum += sad4_tab[mb][k];
            modes[3*k +: 3] = 3'(mode4_tab[mb][k]);
        end
        is16 = (sad16_tab[mb] <= sum) ? 1 : 0;
        cost = (is16 != 0) ? sad16_tab[mb] : sum;
    endfunction

    task automatic fill_const(input int s4, input int s16);
        for (int m = 0; m < NUM_MB; m++) begin
            for (int k = 0; k < 16; k++) begin
                sad4_tab[m][k]  = s4;
                mode4_tab[m][k] = k % 8;
            end
            sad16_tab[m]  = s16;
            mode16_tab[m] = (m + 3) % 8;
        end
    endtask

    task automatic fill_random();
        for (int m = 0; m < NUM_MB; m++) begin
            int sum = 0;
            for (int k = 0; k < 16; k++) begin
                sad4_tab[m][k]  = int'($urandom_range(0, 255));
                mode4_tab[m][k] = int'($urandom_range(0, 7));
                sum += sad4_tab[m][k];
            end
            case ($urandom_range(0, 2))
                0:       sad16_tab[m] = sum;
                1:       sad16_tab[m] = sum + int'($urandom_range(1, 300));
                default: sad16_tab[m] = (sum > 300) ? sum - int'($urandom_range(1, 300)) : 0;
            endcase
            mode16_tab[m] = int'($urandom_range(0, 7));
        end
    endtask

    task automatic drive_inputs();
        int m = int'(mbnumber);
        if (m < NUM_MB) begin
            sad4_in   = 8'(sad4_tab[m][blk4x4]);
            mode4_in  = 3'(mode4_tab[m][blk4x4]);
            sad16_in  = 16'(sad16_tab[m]);
            mode16_in = 3'(mode16_tab[m]);
        end
    endtask

    // stall_mode: 0 ready always, 1 ready low for first 5 valid cycles, 2 random ready
    task automatic run_frame(input int stall_mode, input int extra_start);
        logic [80:0] snap;
        int held = 0, pulsed = 0, j = 0;
        n_res = 0; first_valid_j = -1; done_j = -1; done_cnt = 0; busy_bad = 0;
        emit_enable_bad = 0; emit_mb_bad = 0; unstable = 0; stall_seen = 0; timed_out = 0;
        snap = '0;
        @(negedge clk);
        start = 1'b1;
        drive_inputs();
        @(negedge clk);
        start = 1'b0;
        busy_after_start = int'(busy);
        while (done_cnt == 0 && j < 3000) begin
            drive_inputs();
            start = 1'b0;
            if (extra_start != 0 && pulsed == 0 && mbnumber == 13'd1 && enable && blk4x4 == 4'd3) begin
                start = 1'b1;
                pulsed = 1;
            end
            case (stall_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !(out_valid && stall_seen < 5);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid) begin
                if (first_valid_j < 0) first_valid_j = j;
                if (enable) emit_enable_bad++;
                if (mbnumber != out_mbnumber) emit_mb_bad++;
                if (held != 0 && snap != {out_mbnumber, out_is16, out_mode16, out_modes4, out_cost})
                    unstable++;
                snap = {out_mbnumber, out_is16, out_mode16, out_modes4, out_cost};
                held = out_ready ? 0 : 1;
                if (!out_ready) stall_seen++;
                else begin
                    if (n_res < 8) begin
                        r_mb[n_res]     = int'(out_mbnumber);
                        r_is16[n_res]   = int'(out_is16);
                        r_cost[n_res]   = int'(out_cost);
                        r_mode16[n_res] = int'(out_mode16);
                        r_modes[n_res]  = out_modes4;
                    end
                    n_res++;
                end
            end else begin
                held = 0;
            end
            if (done) begin
                done_cnt++;
                done_j = j;
                if (busy) busy_bad++;
            end
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        done_after = int'(done);
        if (j >= 3000) timed_out = 1;
    endtask

    task automatic test_reset();
        int en_seen = 0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_outs()); end
        reset = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (enable !== 1'b0) en_seen++;
        end
        checks++;
        if (en_seen != 0) begin errors++; $display("FAIL idle_enable: got %0d cycles high want 0", en_seen); end
        checks++;
        if (all_outs() !== '0) begin errors++; $display("FAIL idle_outputs: got %h want 0", all_outs()); end
    endtask

    task automatic test_sad4_wins();
        int e16, ec;
        logic [47:0] em;
        fill_const(5, 100);
        run_frame(0, 0);
        checks++;
        if (timed_out != 0) begin errors++; $display("FAIL s4_timeout: got no done want done"); end
        checks++;
        if (busy_after_start != 1) begin errors++; $display("FAIL s4_busy_start: got %0d want 1", busy_after_start); end
        checks++;
        if (first_valid_j != LAT) begin errors++; $display("FAIL s4_latency: got %0d want %0d", first_valid_j, LAT); end
        checks++;
        if (n_res != NUM_MB) begin errors++; $display("FAIL s4_count: got %0d want %0d", n_res, NUM_MB); end
        for (int m = 0; m < NUM_MB && m < n_res; m++) begin
            model(m, e16, ec, em);
            checks++;
            if (r_mb[m] != m || r_is16[m] != e16 || r_cost[m] != ec || r_modes[m] !== em ||
                r_mode16[m] != mode16_tab[m]) begin
                errors++;
                $display("FAIL s4_result%0d: got mb=%0d is16=%0d cost=%0d modes=%h mode16=%0d want mb=%0d is16=%0d cost=%0d modes=%h mode16=%0d",
                         m, r_mb[m], r_is16[m], r_cost[m], r_modes[m], r_mode16[m], m, e16, ec, em, mode16_tab[m]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_after != 0) begin errors++; $display("FAIL s4_done_pulse: got count=%0d after=%0d want 1/0", done_cnt, done_after); end
        checks++;
        if (done_j != NUM_MB * (LAT + 1)) begin errors++; $display("FAIL s4_done_time: got %0d want %0d", done_j, NUM_MB * (LAT + 1)); end
        checks++;
        if (busy_bad != 0 || busy !== 1'b0 || enable !== 1'b0) begin
            errors++; $display("FAIL s4_busy_end: got busy_at_done=%0d busy=%b enable=%b want 0", busy_bad, busy, enable);
        end
    endtask

    task automatic test_tie();
        fill_const(10, 160);
        run_frame(0, 0);
        checks++;
        if (n_res != NUM_MB || timed_out != 0) begin errors++; $display("FAIL tie_count: got %0d want %0d", n_res, NUM_MB); end
        for (int m = 0; m < NUM_MB && m < n_res; m++) begin
            checks++;
            if (r_is16[m] != 1 || r_cost[m] != 160) begin
                errors++; $display("FAIL tie_result%0d: got is16=%0d cost=%0d want 1/160", m, r_is16[m], r_cost[m]);
            end
        end
    endtask

    task automatic test_backpressure();
        fill_const(3, 500);
        run_frame(1, 0);
        checks++;
        if (stall_seen != 5) begin errors++; $display("FAIL bp_stalls: got %0d want 5", stall_seen); end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
        checks++;
        if (emit_enable_bad != 0 || emit_mb_bad != 0) begin
            errors++; $display("FAIL bp_emit_ctrl: got enable_high=%0d mb_moved=%0d want 0/0", emit_enable_bad, emit_mb_bad);
        end
        checks++;
        if (n_res < 1 || r_mb[0] != 0 || r_modes[0] !== 48'hFAC688_FAC688) begin
            errors++; $display("FAIL bp_modes: got mb=%0d modes=%h want 0/fac688fac688", r_mb[0], r_modes[0]);
        end
        checks++;
        if (done_j != NUM_MB * (LAT + 1) + 5 || n_res != NUM_MB) begin
            errors++; $display("FAIL bp_done_time: got %0d results=%0d want %0d/%0d", done_j, n_res, NUM_MB * (LAT + 1) + 5, NUM_MB);
        end
    endtask

    task automatic test_start_ignored();
        fill_const(7, 90);
        run_frame(0, 1);
        checks++;
        if (n_res != NUM_MB || r_mb[0] != 0 || r_mb[1] != 1) begin
            errors++; $display("FAIL busy_start_seq: got n=%0d mb0=%0d mb1=%0d want %0d/0/1", n_res, r_mb[0], r_mb[1], NUM_MB);
        end
        checks++;
        if (done_cnt != 1 || done_j != NUM_MB * (LAT + 1)) begin
            errors++; $display("FAIL busy_start_done: got count=%0d time=%0d want 1/%0d", done_cnt, done_j, NUM_MB * (LAT + 1));
        end
    endtask

    task automatic test_async_reset();
        int e16, ec, found = 0;
        logic [47:0] em;
        fill_const(7, 4000);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 200 && found == 0; j++) begin
            drive_inputs();
            if (mbnumber == 13'd0 && enable && blk4x4 == 4'd7) found = 1;
            else @(negedge clk);
        end
        checks++;
        if (found == 0) begin
            errors++; $display("FAIL rst_reach_blk7: got blk=%0d want 7", blk4x4);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (all_outs() !== '0) begin errors++; $display("FAIL rst_async_outputs: got %h want 0", all_outs()); end
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin errors++; $display("FAIL rst_held_outputs: got %h want 0", all_outs()); end
        reset = 1'b1;
        fill_random();
        run_frame(0, 0);
        checks++;
        if (n_res != NUM_MB || done_cnt != 1 || first_valid_j != LAT) begin
            errors++; $display("FAIL rst_restart: got n=%0d done=%0d lat=%0d want %0d/1/%0d", n_res, done_cnt, first_valid_j, NUM_MB, LAT);
        end
        for (int m = 0; m < NUM_MB && m < n_res; m++) begin
            model(m, e16, ec, em);
            checks++;
            if (r_mb[m] != m || r_is16[m] != e16 || r_cost[m] != ec || r_modes[m] !== em) begin
                errors++;
                $display("FAIL rst_result%0d: got mb=%0d is16=%0d cost=%0d modes=%h want mb=%0d is16=%0d cost=%0d modes=%h",
                         m, r_mb[m], r_is16[m], r_cost[m], r_modes[m], m, e16, ec, em);
            end
        end
    endtask

    task automatic test_back_to_back();
        int e16, ec;
        logic [47:0] em;
        for (int f = 0; f < 4; f++) begin
            fill_random();
            run_frame(2, 0);
            checks++;
            if (n_res != NUM_MB || done_cnt != 1 || unstable != 0 || timed_out != 0) begin
                errors++; $display("FAIL b2b_frame%0d: got n=%0d done=%0d unstable=%0d timeout=%0d want %0d/1/0/0",
                                   f, n_res, done_cnt, unstable, timed_out, NUM_MB);
            end
            for (int m = 0; m < NUM_MB && m < n_res; m++) begin
                model(m, e16, ec, em);
                checks++;
                if (r_mb[m] != m || r_is16[m] != e16 || r_cost[m] != ec || r_modes[m] !== em ||
                    r_mode16[m] != mode16_tab[m]) begin
                    errors++;
                    $display("FAIL b2b_result%0d_%0d: got mb=%0d is16=%0d cost=%0d modes=%h mode16=%0d want mb=%0d is16=%0d cost=%0d modes=%h mode16=%0d",
                             f, m, r_mb[m], r_is16[m], r_cost[m], r_modes[m], r_mode16[m], m, e16, ec, em, mode16_tab[m]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sad4_wins();
        test_tie();
        test_backpressure();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
